gin_bus: RTL and testbench

GIN_BUS -- requirements
Module: gin_bus

---
 rtl/gin_bus.sv | 89 ++++++++
 tb/tb_gin_bus.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gin_bus.sv
// gin_bus: tag-routed multicast distribution bus with a serial ID scan chain.
// Each downstream master owns one ID register. The IDs are loaded by shifting
// them in through id_scan_in while set_id is high. The last ID leaves on
// id_scan_out, so several buses can be daisy-chained.
// An incoming {enable, tag, value} word is presented combinationally to every
// master whose ID equals the tag. The source sees ready only when all of those
// masters are ready, so a multicast completes in one cycle or stalls as a whole.
// The bus holds no data of its own.
// Optional feature: define GIN_BROADCAST_EN to make the all-ones tag address
// every master regardless of its ID.
module gin_bus #(
  parameter int MASTER_NUMS = 14,
  parameter int ID_LEN      = 4,
  parameter int VALUE_LEN   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_LEN+VALUE_LEN:0]   enable_tag_value,
  output logic                        ready,
  input  logic                        master_ready       [MASTER_NUMS],
  output logic [VALUE_LEN:0]          master_enable_data [MASTER_NUMS],
  input  logic                        set_id,
  input  logic [ID_LEN-1:0]           id_scan_in,
  output logic [ID_LEN-1:0]           id_scan_out
);

  // Fields of the incoming word: enable is the MSB and value is in the LSBs.
  logic                 in_enable;
  logic [ID_LEN-1:0]    in_tag;
  logic [VALUE_LEN-1:0] in_value;

  assign in_enable = enable_tag_value[ID_LEN+VALUE_LEN];
  assign in_tag    = enable_tag_value[ID_LEN+VALUE_LEN-1:VALUE_LEN];
  assign in_value  = enable_tag_value[VALUE_LEN-1:0];

  // ID chain state and its next-state value.
  logic [ID_LEN-1:0] id_q [MASTER_NUMS];
  logic [ID_LEN-1:0] id_d [MASTER_NUMS];

  // Per-master match, and "this master does not block the transfer".
  logic [MASTER_NUMS-1:0] match;
  logic [MASTER_NUMS-1:0] accept;

  // Data may only be delivered outside reset and outside ID programming.
  logic deliver_ok;
  assign deliver_ok = ~rst & ~set_id;

  // With broadcast support, the all-ones tag overrides the ID compare.
  logic tag_bcast;
`ifdef GIN_BROADCAST_EN
  localparam logic [ID_LEN-1:0] BCAST_TAG = '1;
  assign tag_bcast = (in_tag == BCAST_TAG);
`else
  assign tag_bcast = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < MASTER_NUMS; gi++) begin : g_master
      // Scan chain next state: the head takes the serial input, and every
      // other stage takes its upstream neighbour. All stages hold while idle.
      if (gi == 0) begin : g_head
        assign id_d[gi] = set_id ? id_scan_in : id_q[gi];
      end else begin : g_body
        assign id_d[gi] = set_id ? id_q[gi-1] : id_q[gi];
      end

      assign match[gi]  = (id_q[gi] == in_tag) | tag_bcast;
      assign accept[gi] = ~match[gi] | master_ready[gi];

      // The value fans out to every master. Only matching masters see enable.
      assign master_enable_data[gi] = {in_enable & match[gi] & deliver_ok, in_value};
    end
  endgenerate

  // ID registers: reset to all-ones, and shift on every edge with set_id high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MASTER_NUMS; k++) id_q[k] <= '1;
    end else begin
      for (int k = 0; k < MASTER_NUMS; k++) id_q[k] <= id_d[k];
    end
  end

  // When no master matches, accept is all ones and the word is dropped.
  assign ready       = deliver_ok & (&accept);
  assign id_scan_out = id_q[MASTER_NUMS-1];

endmodule

// File: tb/tb_gin_bus.sv
// tb_gin_bus: self-checking bench for gin_bus.
// The bench has four parts:
//  - Directed reset and scan-load sequences.
//  - A table of hand-derived routing vectors.
//  - Multi-cycle corner cases: stall and hold, shift with data, reset during a shift.
//  - A randomized phase checked against a queue-based model of the ID chain.
module tb_gin_bus;
  localparam int N  = 14;
  localparam int IL = 4;
  localparam int VL = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [IL+VL:0]  etv;
  logic            ready;
  logic            mready [N];
  logic [VL:0]     med    [N];
  logic            set_id;
  logic [IL-1:0]   scan_in;
  logic [IL-1:0]   scan_out;

  gin_bus #(.MASTER_NUMS(N), .ID_LEN(IL), .VALUE_LEN(VL)) dut (
    .clk                (clk),
    .rst                (rst),
    .enable_tag_value   (etv),
    .ready              (ready),
    .master_ready       (mready),
    .master_enable_data (med),
    .set_id             (set_id),
    .id_scan_in         (scan_in),
    .id_scan_out        (scan_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference chain: element 0 is master 0. A shift pushes a new ID onto the
  // front of the queue, and the oldest ID falls off the back.
  logic [IL-1:0] model_ids [$];

`ifdef GIN_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  typedef struct {
    string          nm;
    logic           en;
    logic [IL-1:0]  tag;
    logic [VL-1:0]  val;
    logic [N-1:0]   mr;
    logic [N-1:0]   exp_en;
    logic           exp_rdy;
  } vec_t;

  vec_t vt [$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
      $display("check %-14s actual %0h required %0h ok", nm, act, exp);
    end else begin
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sid, input logic [IL-1:0] sin, input logic en,
                       input logic [IL-1:0] tag, input logic [VL-1:0] val,
                       input logic [N-1:0] mr);
    set_id  = sid;
    scan_in = sin;
    etv     = {en, tag, val};
    for (int i = 0; i < N; i++) mready[i] = mr[i];
  endtask

  function automatic logic [N-1:0] dut_en();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = med[i][VL];
    return r;
  endfunction

  function automatic int val_hits(input logic [VL-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) if (med[i][VL-1:0] === v) c++;
    return c;
  endfunction

  task automatic model_shift(input logic [IL-1:0] v);
    model_ids.push_front(v);
    void'(model_ids.pop_back());
  endtask

  task automatic model_reset();
    model_ids.delete();
    for (int i = 0; i < N; i++) model_ids.push_back('1);
  endtask

  // One shift cycle with no data offered. The model follows the edge that comes next.
  task automatic shift_in(input logic [IL-1:0] v);
    @(negedge clk);
    drive(1'b1, v, 1'b0, '0, '0, '1);
    model_shift(v);
  endtask

  // Compare the current outputs against expectations derived from the model.
  task automatic check_model(input string nm, input logic sid, input logic en,
                             input logic [IL-1:0] tag, input logic [VL-1:0] val,
                             input logic [N-1:0] mr);
    logic [N-1:0] e;
    int blockers;
    e = '0;
    blockers = 0;
    for (int i = 0; i < N; i++) begin
      bit hit;
      hit = (model_ids[i] == tag) || (BCAST && tag == 4'hF);
      if (hit && !mr[i]) blockers++;
      if (hit && en && !sid) e[i] = 1'b1;
    end
    cmp({nm, ".en"}, 32'(dut_en()), 32'(e));
    cmp({nm, ".rdy"}, 32'(ready), 32'((!sid && blockers == 0) ? 1 : 0));
    cmp({nm, ".scan"}, 32'(scan_out), 32'(model_ids[N-1]));
    cmp({nm, ".val"}, 32'(val_hits(val)), 32'(N));
  endtask

  initial begin
    logic [N-1:0] mr;
    logic [IL-1:0] tag, v;
    logic [VL-1:0] val;
    logic en, sid;

    // Routing vectors for the chain loaded with id[i] = i mod 7.
    vt.push_back('{"t0_v00", 1'b1, 4'd0, 8'h00, 14'h3FFF, 14'h0081, 1'b1});
    for (int t = 0; t < 7; t++)
      vt.push_back('{$sformatf("sweep_t%0d", t), 1'b1, 4'(t), 8'(8'hFF - t), 14'h3FFF,
                     14'((1 << t) | (1 << (t + 7))), 1'b1});
    vt.push_back('{"t3_stall", 1'b1, 4'd3, 8'h33, 14'h3BFF, 14'h0408, 1'b0});
    vt.push_back('{"t3_go", 1'b1, 4'd3, 8'h33, 14'h3FFF, 14'h0408, 1'b1});
    vt.push_back('{"t9_drop", 1'b1, 4'd9, 8'h99, 14'h3FFF, 14'h0000, 1'b1});
    vt.push_back('{"en0_t5_busy", 1'b0, 4'd5, 8'h55, 14'h3FDF, 14'h0000, 1'b0});
    vt.push_back('{"en0_t9", 1'b0, 4'd9, 8'h11, 14'h0000, 14'h0000, 1'b1});
    vt.push_back('{"tF_5a", 1'b1, 4'hF, 8'h5A, 14'h3FFF, BCAST ? 14'h3FFF : 14'h0000, 1'b1});
    vt.push_back('{"tF_m0busy", 1'b1, 4'hF, 8'hA5, 14'h3FFE, BCAST ? 14'h3FFF : 14'h0000,
                   BCAST ? 1'b0 : 1'b1});
    vt.push_back('{"t6_only_own", 1'b1, 4'd6, 8'h66, 14'h2040, 14'h2040, 1'b1});

    // While reset is held, the IDs are all ones and nothing is delivered.
    // Tag F would match the all-ones IDs if reset did not gate the outputs.
    rst = 1'b1;
    drive(1'b0, '0, 1'b1, 4'hF, 8'h33, '1);
    #2;
    cmp("rst.scan", 32'(scan_out), 32'hF);
    cmp("rst.en", 32'(dut_en()), 32'h0);
    cmp("rst.rdy", 32'(ready), 32'h0);
    model_reset();

    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("post_rst.en", 32'(dut_en()), 32'h3FFF);
    cmp("post_rst.rdy", 32'(ready), 32'h1);

    // Load id[i] = i mod 7 with 14 shifts.
    for (int s = 0; s < 14; s++) begin
      shift_in(4'(6 - (s % 7)));
      if (s == 13) begin
        #1;
        cmp("scan13", 32'(scan_out), 32'hF);
      end
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0, '1);
    #1;
    cmp("scan14", 32'(scan_out), 32'h6);

    // Apply the routing table.
    foreach (vt[k]) begin
      @(negedge clk);
      drive(1'b0, '0, vt[k].en, vt[k].tag, vt[k].val, vt[k].mr);
      #1;
      cmp({vt[k].nm, ".en"}, 32'(dut_en()), 32'(vt[k].exp_en));
      cmp({vt[k].nm, ".rdy"}, 32'(ready), 32'(vt[k].exp_rdy));
      cmp({vt[k].nm, ".val"}, 32'(val_hits(vt[k].val)), 32'(N));
    end

    // The source holds a stalled word for several cycles, then master 10 frees it.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b0, '0, 1'b1, 4'd3, 8'hC3, 14'h3BFF);
      #1;
      cmp($sformatf("hold%0d.rdy", c), 32'(ready), 32'h0);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 4'd3, 8'hC3, 14'h3FFF);
    #1;
    cmp("release.rdy", 32'(ready), 32'h1);
    cmp("release.en", 32'(dut_en()), 32'h0408);

    // A shift with enable high delivers nothing, and the IDs still move.
    @(negedge clk);
    drive(1'b1, 4'h2, 1'b1, 4'd0, 8'h77, '1);
    #1;
    cmp("sid_en.en", 32'(dut_en()), 32'h0);
    cmp("sid_en.rdy", 32'(ready), 32'h0);
    model_shift(4'h2);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0, '1);
    #1;
    cmp("sid_en.scan", 32'(scan_out), 32'(model_ids[N-1]));

    // Reset arrives between clock edges in the middle of a reload.
    shift_in(4'h1);
    shift_in(4'h2);
    @(negedge clk);
    drive(1'b1, 4'h3, 1'b0, '0, '0, '1);
    #2;
    rst = 1'b1;
    #1;
    cmp("mid_rst.scan", 32'(scan_out), 32'hF);
    cmp("mid_rst.rdy", 32'(ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, '1);
    #1;
    cmp("after_rst.scan", 32'(scan_out), 32'hF);

    // Full reload with random IDs, followed by randomized traffic against the model.
    for (int s = 0; s < N; s++) shift_in(4'($urandom_range(0, 15)));
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      sid = ($urandom_range(0, 9) == 0);
      v   = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 3) != 0);
      tag = ($urandom_range(0, 1) == 1) ? model_ids[$urandom_range(0, N-1)]
                                        : 4'($urandom_range(0, 15));
      val = 8'($urandom);
      mr  = '1;
      if ($urandom_range(0, 2) == 0) mr = 14'($urandom) | 14'($urandom);
      drive(sid, v, en, tag, val, mr);
      #1;
      check_model($sformatf("rnd%0d", c), sid, en, tag, val, mr);
      if ($urandom_range(0, 59) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        cmp($sformatf("rnd%0d.rst", c), 32'(scan_out), 32'hF);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end else if (sid) begin
        model_shift(v);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
